// File: rtl/alu_cmd_issuer.sv
// ============================================================================
// Module  : alu_cmd_issuer
// Brief   : Credit-based command issuer for a fixed-latency pipelined ALU,
//           with in-order response FIFO. Optional macro ALU_CMD_OPCHK_EN
//           adds a per-response illegal-opcode flag (rsp_err).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_issuer #(
    parameter int ALU_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int TAG_W       = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [7:0]                  cmd_a,
    input  logic [7:0]                  cmd_b,
    input  logic [2:0]                  cmd_op,
    input  logic [TAG_W-1:0]            cmd_tag,
    output logic [7:0]                  alu_a,
    output logic [7:0]                  alu_b,
    output logic [2:0]                  alu_op,
    input  logic [15:0]                 alu_result,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [15:0]                 rsp_result,
    output logic [TAG_W-1:0]            rsp_tag,
    output logic [2:0]                  rsp_op,
`ifdef ALU_CMD_OPCHK_EN
    output logic                        rsp_err,
`endif
    output logic [$clog2(FIFO_DEPTH):0] inflight,
    output logic                        busy
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_PIPE  = ALU_LATENCY + 1;
    localparam logic [2:0]         c_IDLE_OP = 3'b111;
    localparam logic [c_CNT_W:0]   c_DEPTH   = (c_CNT_W + 1)'(FIFO_DEPTH);

    logic                 r_trk_vld [c_PIPE];
    logic [TAG_W-1:0]     r_trk_tag [c_PIPE];
    logic [2:0]           r_trk_op  [c_PIPE];

    logic [15:0]          r_mem_res [FIFO_DEPTH];
    logic [TAG_W-1:0]     r_mem_tag [FIFO_DEPTH];
    logic [2:0]           r_mem_op  [FIFO_DEPTH];

    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   r_inflight;

    logic [c_CNT_W:0]     w_used;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;

    // Credits cover both in-flight commands and buffered responses, so a
    // FIFO slot always exists by the time a result emerges from the ALU.
    assign w_used    = {1'b0, r_inflight} + {1'b0, r_count};
    assign cmd_ready = !reset && (w_used < c_DEPTH);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_push    = r_trk_vld[c_PIPE-1];
    assign w_pop     = rsp_valid && rsp_ready;

    assign rsp_valid  = (r_count != '0);
    assign rsp_result = r_mem_res[r_rd_ptr];
    assign rsp_tag    = r_mem_tag[r_rd_ptr];
    assign rsp_op     = r_mem_op[r_rd_ptr];
    assign inflight   = r_inflight;
    assign busy       = (r_inflight != '0) || rsp_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= c_IDLE_OP;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            for (int i = 0; i < c_PIPE; i++) begin
                r_trk_vld[i] <= 1'b0;
                r_trk_tag[i] <= '0;
                r_trk_op[i]  <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_res[i] <= '0;
                r_mem_tag[i] <= '0;
                r_mem_op[i]  <= '0;
            end
        end else begin
            alu_a  <= w_accept ? cmd_a  : '0;
            alu_b  <= w_accept ? cmd_b  : '0;
            alu_op <= w_accept ? cmd_op : c_IDLE_OP;

            // Tracking pipe mirrors the ALU latency plus the issue register.
            r_trk_vld[0] <= w_accept;
            r_trk_tag[0] <= w_accept ? cmd_tag : '0;
            r_trk_op[0]  <= w_accept ? cmd_op  : '0;
            for (int i = 1; i < c_PIPE; i++) begin
                r_trk_vld[i] <= r_trk_vld[i-1];
                r_trk_tag[i] <= r_trk_tag[i-1];
                r_trk_op[i]  <= r_trk_op[i-1];
            end

            if (w_push) begin
                r_mem_res[r_wr_ptr] <= alu_result;
                r_mem_tag[r_wr_ptr] <= r_trk_tag[c_PIPE-1];
                r_mem_op[r_wr_ptr]  <= r_trk_op[c_PIPE-1];
                r_wr_ptr            <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            case ({w_accept, w_push})
                2'b10:   r_inflight <= r_inflight + c_CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - c_CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

`ifdef ALU_CMD_OPCHK_EN
    logic r_mem_err [FIFO_DEPTH];

    assign rsp_err = r_mem_err[r_rd_ptr];

    // Opcodes 110 and 111 have no ALU function; flag them per entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_err[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_mem_err[r_wr_ptr] <= &r_trk_op[c_PIPE-1][2:1];
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
// ============================================================================
// Module  : tb_alu_cmd_issuer
// Brief   : Directed scoreboard bench for alu_cmd_issuer with a 2-cycle ALU model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_issuer;

    localparam int FIFO_DEPTH = 4;
    localparam int TAG_W      = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_a;
    logic [7:0]       cmd_b;
    logic [2:0]       cmd_op;
    logic [TAG_W-1:0] cmd_tag;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [2:0]       alu_op;
    logic [15:0]      alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic [2:0]       rsp_op;
    logic [2:0]       inflight;
    logic             busy;
`ifdef ALU_CMD_OPCHK_EN
    logic             rsp_err;
`endif

    alu_cmd_issuer #(
        .ALU_LATENCY (2),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TAG_W       (TAG_W)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .cmd_tag    (cmd_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag),
        .rsp_op     (rsp_op),
`ifdef ALU_CMD_OPCHK_EN
        .rsp_err    (rsp_err),
`endif
        .inflight   (inflight),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        case (op)
            3'b000:  return {8'h00, a} + {8'h00, b};
            3'b001:  return {8'h00, a} - {8'h00, b};
            3'b010:  return {8'h00, a} * {8'h00, b};
            3'b011:  return {8'h00, a & b};
            3'b100:  return {8'h00, a | b};
            3'b101:  return {8'h00, a ^ b};
            default: return 16'h0000;
        endcase
    endfunction

    // External ALU: samples one edge after issue, result valid one edge later.
    logic [15:0] alu_s1;
    always_ff @(posedge clk) begin
        alu_s1     <= alu_f(alu_a, alu_b, alu_op);
        alu_result <= alu_s1;
    end

    typedef struct packed {
        logic [15:0]      res;
        logic [TAG_W-1:0] tag;
        logic [2:0]       op;
        logic             err;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        last_acc;
    logic [15:0] exp_res;
    logic        exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: log accept/pop from pre-edge handshakes, then step past the edge.
    task automatic tick();
        exp_t e;
        last_acc = cmd_valid && cmd_ready;
        if (last_acc) begin
            e.res = exp_res;
            e.tag = cmd_tag;
            e.op  = cmd_op;
            e.err = exp_err;
            sb.push_back(e);
        end
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_tag", rsp_tag, e.tag);
                chk("rsp_op", rsp_op, e.op);
`ifdef ALU_CMD_OPCHK_EN
                chk("rsp_err", rsp_err, e.err);
`endif
            end
        end
        @(posedge clk);
        #1;
        chk("credit_bound", sb.size() <= FIFO_DEPTH, 1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        while ((sb.size() != 0 || rsp_valid) && g < 40) begin
            tick();
            g++;
        end
        chk("drain_done", sb.size(), 0);
    endtask

    task automatic set_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                           input logic [TAG_W-1:0] tag, input logic [15:0] res, input logic err);
        cmd_a   = a;
        cmd_b   = b;
        cmd_op  = op;
        cmd_tag = tag;
        exp_res = res;
        exp_err = err;
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        chk(tag, n, 3);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] tbl [6];
        logic [15:0] h_res;
        logic [3:0]  h_tag;
        logic [2:0]  h_op;
        int idx, guard, accepts, seen;

        tbl[0] = 16'h012C; tbl[1] = 16'h00B4; tbl[2] = 16'h3840;
        tbl[3] = 16'h0030; tbl[4] = 16'h00FC; tbl[5] = 16'h00CC;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        set_cmd(8'h00, 8'h00, 3'b000, '0, 16'h0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 3'b111);
        chk("rst_inflight", inflight, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_rsp_op", rsp_op, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // Single add with latency measurement.
        rsp_ready = 1'b1;
        set_cmd(8'd200, 8'd100, 3'b000, 4'd3, 16'd300, 1'b0);
        cmd_valid = 1'b1;
        tick();
        chk("single_accept", last_acc, 1);
        cmd_valid = 1'b0;
        chk("single_inflight", inflight, 1);
        chk("single_alu_a", alu_a, 200);
        chk("single_busy", busy, 1);
        wait_rsp("single_latency");
        chk("single_result", rsp_result, 16'd300);
        chk("single_tag", rsp_tag, 3);
        drain();

        // Back-to-back through every defined opcode.
        idx = 0;
        guard = 0;
        while (idx < 6 && guard < 40) begin
            set_cmd(8'hF0, 8'h3C, 3'(idx), 4'(idx), tbl[idx], 1'b0);
            cmd_valid = 1'b1;
            tick();
            if (last_acc) idx++;
            guard++;
            if (guard == 4) chk("b2b_first4_accepted", idx, 4);
        end
        chk("b2b_issued", idx, 6);
        drain();

        // Backpressure: credits run out at FIFO_DEPTH.
        rsp_ready = 1'b0;
        accepts = 0;
        for (int k = 0; k < 12; k++) begin
            set_cmd(8'(17 * accepts + 1), 8'(3 * accepts + 7), 3'(accepts % 6), 4'(8 + accepts),
                    alu_f(8'(17 * accepts + 1), 8'(3 * accepts + 7), 3'(accepts % 6)), 1'b0);
            cmd_valid = 1'b1;
            tick();
            if (last_acc) accepts++;
            if (k == 9) begin
                h_res = rsp_result;
                h_tag = rsp_tag;
                h_op  = rsp_op;
            end
        end
        chk("bp_accepts", accepts, FIFO_DEPTH);
        chk("bp_cmd_ready", cmd_ready, 0);
        chk("bp_inflight", inflight, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_hold_result", rsp_result, h_res);
        chk("bp_hold_tag", rsp_tag, h_tag);
        chk("bp_hold_op", rsp_op, h_op);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_credit_back", cmd_ready, 1);
        set_cmd(8'h21, 8'h12, 3'b100, 4'hC, 16'h0033, 1'b0);
        tick();
        chk("bp_extra_accept", last_acc, 1);
        cmd_valid = 1'b0;
        chk("bp_full_again", cmd_ready, 0);
        drain();

        // Wrap-around arithmetic and an undefined opcode.
        cmd_valid = 1'b1;
        set_cmd(8'd5, 8'd10, 3'b001, 4'd1, 16'hFFFB, 1'b0);
        tick();
        set_cmd(8'd255, 8'd255, 3'b010, 4'd2, 16'hFE01, 1'b0);
        tick();
        set_cmd(8'h55, 8'h66, 3'b111, 4'd7, 16'h0000, 1'b1);
        tick();
        drain();

        // Reset while three commands are in flight.
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_cmd(8'(k + 1), 8'(k + 2), 3'b000, 4'(k), 16'(2 * k + 3), 1'b0);
            tick();
        end
        cmd_valid = 1'b0;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_inflight", inflight, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_alu_op", alu_op, 3'b111);
        #2;
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rsp_valid) seen++;
        end
        chk("post_rst_no_rsp", seen, 0);
        chk("post_rst_inflight", inflight, 0);
        set_cmd(8'd7, 8'd9, 3'b010, 4'hA, 16'd63, 1'b0);
        cmd_valid = 1'b1;
        tick();
        chk("post_rst_accept", last_acc, 1);
        cmd_valid = 1'b0;
        wait_rsp("post_rst_latency");
        chk("post_rst_result", rsp_result, 16'd63);
        drain();

`ifdef ALU_CMD_OPCHK_EN
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        set_cmd(8'hFF, 8'hFF, 3'b110, 4'd5, 16'h0000, 1'b1);
        tick();
        set_cmd(8'hF0, 8'h3C, 3'b011, 4'd6, 16'h0030, 1'b0);
        tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        chk("opchk_err_head", rsp_err, 1);
        chk("opchk_res_head", rsp_result, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("opchk_err_next", rsp_err, 0);
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
